// File: rtl/multicycle_control_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_control_sequencer
//
// Multi-cycle control FSM for the accumulator CPU. It steps the datapath
// through FETCH -> DECODE -> EXEC, and waits on the instruction and data
// memory ready handshakes. On HLT it parks in HALT. After reset it spends
// one INIT cycle clearing every datapath register.
//
// Ports
//   clock_in, reset_in           clock (rising edge), async active-low reset
//   op_code                      opcode field from the IR output
//   status_Z_in, status_N_in     zero / negative flags from the status register
//   instr_ready_in               instruction memory data valid
//   data_ready_in                data memory read valid / write accepted
//   instr_req_out, data_req_out  memory access requests
//   branch_out                   PC source (1 = branch target, 0 = PC+1)
//   sel_A_out                    ACC input mux (00 ALU, 01 immediate, 10 memory)
//   sel_B_out                    ALU B operand (0 memory, 1 immediate)
//   alu_op_out                   0 add, 1 subtract
//   data_memory_wr_out           data memory write strobe
//   *_wr_out                     register write enables
//   *_reset_out                  synchronous register clears
//   halted_out                   core stopped on HLT
// -----------------------------------------------------------------------------
module multicycle_control_sequencer #(
    parameter int DATA_WIDTH        = 11,
    parameter int INSTRUCTION_WIDTH = 15,
    parameter int OPCODE_WIDTH      = INSTRUCTION_WIDTH - DATA_WIDTH + 1
) (
    input  logic                    clock_in,
    input  logic                    reset_in,
    input  logic [OPCODE_WIDTH-1:0] op_code,
    input  logic                    status_Z_in,
    input  logic                    status_N_in,
    input  logic                    instr_ready_in,
    input  logic                    data_ready_in,
    output logic                    instr_req_out,
    output logic                    data_req_out,
    output logic                    branch_out,
    output logic [1:0]              sel_A_out,
    output logic                    sel_B_out,
    output logic                    alu_op_out,
    output logic                    data_memory_wr_out,
    output logic                    acc_wr_out,
    output logic                    pc_wr_out,
    output logic                    status_wr_out,
    output logic                    ir_wr_out,
    output logic                    acc_reset_out,
    output logic                    pc_reset_out,
    output logic                    status_reset_out,
    output logic                    ir_reset_out,
    output logic                    halted_out
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(9);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGT  = OPCODE_WIDTH'(10);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGE  = OPCODE_WIDTH'(11);
    localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = OPCODE_WIDTH'(12);
    localparam logic [OPCODE_WIDTH-1:0] OP_BLE  = OPCODE_WIDTH'(13);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(14);

    state_t                  state, state_next;
    logic [OPCODE_WIDTH-1:0] opcode_q;

    // Reset lands in INIT, and INIT decodes to "clear everything". So every
    // write enable and request drops in the same instant that reset_in falls.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process ordering.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state    <= S_INIT;
            opcode_q <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                opcode_q <= op_code;
            end
        end
    end

    // NOTE: every output of this block gets a default before the case
    // statement, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next         = state;
        instr_req_out      = 1'b0;
        data_req_out       = 1'b0;
        branch_out         = 1'b0;
        sel_A_out          = 2'b00;
        sel_B_out          = 1'b0;
        alu_op_out         = 1'b0;
        data_memory_wr_out = 1'b0;
        acc_wr_out         = 1'b0;
        pc_wr_out          = 1'b0;
        status_wr_out      = 1'b0;
        ir_wr_out          = 1'b0;
        acc_reset_out      = 1'b0;
        pc_reset_out       = 1'b0;
        status_reset_out   = 1'b0;
        ir_reset_out       = 1'b0;
        halted_out         = 1'b0;

        case (state)
            S_INIT: begin
                acc_reset_out    = 1'b1;
                pc_reset_out     = 1'b1;
                status_reset_out = 1'b1;
                ir_reset_out     = 1'b1;
                state_next       = S_FETCH;
            end

            S_FETCH: begin
                instr_req_out = 1'b1;
                if (instr_ready_in) begin
                    ir_wr_out  = 1'b1;
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                state_next = S_EXEC;
            end

            S_EXEC: begin
                case (opcode_q)
                    OP_HLT: begin
                        state_next = S_HALT;
                    end
                    OP_STO: begin
                        data_req_out = 1'b1;
                        if (data_ready_in) begin
                            data_memory_wr_out = 1'b1;
                            pc_wr_out          = 1'b1;
                            state_next         = S_FETCH;
                        end
                    end
                    OP_LD: begin
                        data_req_out = 1'b1;
                        if (data_ready_in) begin
                            sel_A_out     = 2'b10;
                            acc_wr_out    = 1'b1;
                            status_wr_out = 1'b1;
                            pc_wr_out     = 1'b1;
                            state_next    = S_FETCH;
                        end
                    end
                    OP_LDI: begin
                        sel_A_out     = 2'b01;
                        acc_wr_out    = 1'b1;
                        status_wr_out = 1'b1;
                        pc_wr_out     = 1'b1;
                        state_next    = S_FETCH;
                    end
                    OP_ADD, OP_SUB: begin
                        data_req_out = 1'b1;
                        if (data_ready_in) begin
                            alu_op_out    = (opcode_q == OP_SUB);
                            acc_wr_out    = 1'b1;
                            status_wr_out = 1'b1;
                            pc_wr_out     = 1'b1;
                            state_next    = S_FETCH;
                        end
                    end
                    OP_ADDI, OP_SUBI: begin
                        sel_B_out     = 1'b1;
                        alu_op_out    = (opcode_q == OP_SUBI);
                        acc_wr_out    = 1'b1;
                        status_wr_out = 1'b1;
                        pc_wr_out     = 1'b1;
                        state_next    = S_FETCH;
                    end
                    OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP: begin
                        pc_wr_out  = 1'b1;
                        state_next = S_FETCH;
                        case (opcode_q)
                            OP_BEQ:  branch_out = status_Z_in;
                            OP_BNE:  branch_out = !status_Z_in;
                            OP_BGT:  branch_out = !status_Z_in && !status_N_in;
                            OP_BGE:  branch_out = !status_N_in;
                            OP_BLT:  branch_out = status_N_in;
                            OP_BLE:  branch_out = status_N_in || status_Z_in;
                            default: branch_out = 1'b1;
                        endcase
                    end
                    default: begin
                        // Unassigned opcodes act as NOP: just step the PC.
                        pc_wr_out  = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end

            S_HALT: begin
                halted_out = 1'b1;
            end

            default: begin
                state_next = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_sequencer
//
// Self-checking bench for multicycle_control_sequencer. For each instruction,
// a reference model builds the expected cycle-by-cycle control trace from the
// instruction semantics and the chosen wait-state counts. Each scenario task
// replays that trace against the DUT. Ready inputs and op_code get random
// values in the cycles where the sequencer must ignore them.
// -----------------------------------------------------------------------------
module tb_multicycle_control_sequencer;

    localparam logic [4:0] HLT = 5'd0,  STO = 5'd1,  LD  = 5'd2,  LDI  = 5'd3;
    localparam logic [4:0] ADD = 5'd4,  ADDI = 5'd5, SUB = 5'd6,  SUBI = 5'd7;
    localparam logic [4:0] BEQ = 5'd8,  BNE = 5'd9,  BGT = 5'd10, BGE  = 5'd11;
    localparam logic [4:0] BLT = 5'd12, BLE = 5'd13, JMP = 5'd14;

    logic       clock_in = 1'b0;
    logic       reset_in = 1'b0;
    logic [4:0] op_code = '0;
    logic       status_Z_in = 1'b0, status_N_in = 1'b0;
    logic       instr_ready_in = 1'b0, data_ready_in = 1'b0;
    logic       instr_req_out, data_req_out, branch_out;
    logic [1:0] sel_A_out;
    logic       sel_B_out, alu_op_out, data_memory_wr_out;
    logic       acc_wr_out, pc_wr_out, status_wr_out, ir_wr_out;
    logic       acc_reset_out, pc_reset_out, status_reset_out, ir_reset_out;
    logic       halted_out;

    int checks = 0;
    int errors = 0;

    multicycle_control_sequencer dut (
        .clock_in          (clock_in),
        .reset_in          (reset_in),
        .op_code           (op_code),
        .status_Z_in       (status_Z_in),
        .status_N_in       (status_N_in),
        .instr_ready_in    (instr_ready_in),
        .data_ready_in     (data_ready_in),
        .instr_req_out     (instr_req_out),
        .data_req_out      (data_req_out),
        .branch_out        (branch_out),
        .sel_A_out         (sel_A_out),
        .sel_B_out         (sel_B_out),
        .alu_op_out        (alu_op_out),
        .data_memory_wr_out(data_memory_wr_out),
        .acc_wr_out        (acc_wr_out),
        .pc_wr_out         (pc_wr_out),
        .status_wr_out     (status_wr_out),
        .ir_wr_out         (ir_wr_out),
        .acc_reset_out     (acc_reset_out),
        .pc_reset_out      (pc_reset_out),
        .status_reset_out  (status_reset_out),
        .ir_reset_out      (ir_reset_out),
        .halted_out        (halted_out)
    );

    always #5 clock_in = ~clock_in;

    // Global watchdog: every wait below is already bounded, but this one
    // guarantees termination even if the stimulus itself goes wrong.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    typedef struct packed {
        logic       instr_req, data_req, branch;
        logic [1:0] sel_a;
        logic       sel_b, alu_op, dmem_wr;
        logic       acc_wr, pc_wr, status_wr, ir_wr;
        logic       acc_rst, pc_rst, status_rst, ir_rst;
        logic       halted;
    } ctl_t;

    typedef struct {
        logic       ir_rdy, d_rdy;
        logic [4:0] opc;
        ctl_t       exp, mask;
    } step_t;

    function automatic ctl_t sample();
        ctl_t c;
        c.instr_req = instr_req_out;  c.data_req  = data_req_out;
        c.branch    = branch_out;     c.sel_a     = sel_A_out;
        c.sel_b     = sel_B_out;      c.alu_op    = alu_op_out;
        c.dmem_wr   = data_memory_wr_out;
        c.acc_wr    = acc_wr_out;     c.pc_wr     = pc_wr_out;
        c.status_wr = status_wr_out;  c.ir_wr     = ir_wr_out;
        c.acc_rst   = acc_reset_out;  c.pc_rst    = pc_reset_out;
        c.status_rst = status_reset_out; c.ir_rst = ir_reset_out;
        c.halted    = halted_out;
        return c;
    endfunction

    function automatic ctl_t resets_only();
        ctl_t c = '0;
        c.acc_rst = 1'b1; c.pc_rst = 1'b1; c.status_rst = 1'b1; c.ir_rst = 1'b1;
        return c;
    endfunction

    // While a data access waits, the mux selects are don't-care; everything
    // that can change architectural state (or the request itself) is checked.
    function automatic ctl_t wait_mask();
        ctl_t m = '1;
        m.branch = 1'b0; m.sel_a = 2'b00; m.sel_b = 1'b0; m.alu_op = 1'b0;
        return m;
    endfunction

    // Reference semantics of the EXEC completion cycle.
    task automatic model(input logic [4:0] op, input logic z, input logic n,
                         output ctl_t c, output bit is_mem);
        c = '0;
        is_mem = 1'b0;
        if (op == HLT) begin
            // nothing written, the core just stops
        end else if (op == STO) begin
            is_mem = 1'b1; c.data_req = 1'b1; c.dmem_wr = 1'b1; c.pc_wr = 1'b1;
        end else if (op == LD) begin
            is_mem = 1'b1; c.data_req = 1'b1; c.sel_a = 2'b10;
            c.acc_wr = 1'b1; c.status_wr = 1'b1; c.pc_wr = 1'b1;
        end else if (op == LDI) begin
            c.sel_a = 2'b01; c.acc_wr = 1'b1; c.status_wr = 1'b1; c.pc_wr = 1'b1;
        end else if (op == ADD || op == SUB) begin
            is_mem = 1'b1; c.data_req = 1'b1; c.alu_op = (op == SUB);
            c.acc_wr = 1'b1; c.status_wr = 1'b1; c.pc_wr = 1'b1;
        end else if (op == ADDI || op == SUBI) begin
            c.sel_b = 1'b1; c.alu_op = (op == SUBI);
            c.acc_wr = 1'b1; c.status_wr = 1'b1; c.pc_wr = 1'b1;
        end else if (op >= BEQ && op <= JMP) begin
            c.pc_wr = 1'b1;
            case (op)
                BEQ: c.branch = z;
                BNE: c.branch = ~z;
                BGT: c.branch = ~z & ~n;
                BGE: c.branch = ~n;
                BLT: c.branch = n;
                BLE: c.branch = n | z;
                default: c.branch = 1'b1;
            endcase
        end else begin
            c.pc_wr = 1'b1;
        end
    endtask

    // Builds the expected trace for one instruction (starting in FETCH) and
    // replays it. Inputs change 1 time unit after a rising edge; outputs are
    // compared on the falling edge.
    task automatic run_instr(input logic [4:0] op, input int iw, input int dw,
                             input logic z, input logic n, output int cycles);
        step_t q[$];
        step_t s;
        ctl_t  fin, act;
        bit    is_mem;
        model(op, z, n, fin, is_mem);
        status_Z_in = z;
        status_N_in = n;
        for (int i = 0; i < iw; i++) begin
            s.ir_rdy = 1'b0; s.d_rdy = 1'($urandom); s.opc = 5'($urandom);
            s.exp = '0; s.exp.instr_req = 1'b1; s.mask = '1;
            q.push_back(s);
        end
        s.ir_rdy = 1'b1; s.d_rdy = 1'($urandom); s.opc = 5'($urandom);
        s.exp = '0; s.exp.instr_req = 1'b1; s.exp.ir_wr = 1'b1; s.mask = '1;
        q.push_back(s);
        s.ir_rdy = 1'($urandom); s.d_rdy = 1'($urandom); s.opc = op;
        s.exp = '0; s.mask = '1;
        q.push_back(s);
        if (is_mem) begin
            for (int i = 0; i < dw; i++) begin
                s.ir_rdy = 1'($urandom); s.d_rdy = 1'b0; s.opc = 5'($urandom);
                s.exp = '0; s.exp.data_req = 1'b1; s.mask = wait_mask();
                q.push_back(s);
            end
        end
        s.ir_rdy = 1'($urandom); s.d_rdy = is_mem ? 1'b1 : 1'($urandom);
        s.opc = 5'($urandom); s.exp = fin; s.mask = '1;
        q.push_back(s);

        foreach (q[i]) begin
            instr_ready_in = q[i].ir_rdy;
            data_ready_in  = q[i].d_rdy;
            op_code        = q[i].opc;
            @(negedge clock_in);
            act = sample();
            checks++;
            if ((act & q[i].mask) !== (q[i].exp & q[i].mask)) begin
                errors++;
                $display("FAIL trace op=%b cycle=%0d z=%b n=%b: got %h expected %h (mask %h)",
                         op, i, z, n, act, q[i].exp, q[i].mask);
            end
            @(posedge clock_in); #1;
        end
        cycles = q.size();
    endtask

    // Releases reset at a point 1 unit after an edge, then checks the single
    // INIT clearing cycle and the first FETCH cycle that follows it.
    task automatic release_reset(input string tag);
        ctl_t act, exp;
        instr_ready_in = 1'b0;
        reset_in = 1'b1;
        @(negedge clock_in);
        act = sample();
        checks++;
        if (act !== resets_only()) begin
            errors++;
            $display("FAIL %s init_cycle: got %h expected %h", tag, act, resets_only());
        end
        @(posedge clock_in); #1;
        @(negedge clock_in);
        act = sample();
        exp = '0; exp.instr_req = 1'b1;
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s first_fetch: got %h expected %h", tag, act, exp);
        end
        @(posedge clock_in); #1;
    endtask

    task automatic test_reset();
        ctl_t act, exp;
        // Power-on reset.
        reset_in = 1'b0;
        #1;
        act = sample();
        checks++;
        if (act !== resets_only()) begin
            errors++;
            $display("FAIL power_on_reset: got %h expected %h", act, resets_only());
        end
        repeat (2) @(posedge clock_in);
        #1;
        release_reset("power_on");

        // STO stalled in EXEC, then reset arrives together with data ready.
        instr_ready_in = 1'b1;
        @(posedge clock_in); #1;
        op_code = STO; instr_ready_in = 1'b0;
        @(posedge clock_in); #1;
        op_code = 5'($urandom);
        data_ready_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock_in);
            act = sample();
            exp = '0; exp.data_req = 1'b1;
            checks++;
            if ((act & wait_mask()) !== exp) begin
                errors++;
                $display("FAIL sto_wait cycle=%0d: got %h expected %h", i, act, exp);
            end
            @(posedge clock_in); #1;
        end
        data_ready_in = 1'b1;
        reset_in = 1'b0;
        #1;
        act = sample();
        checks++;
        if (act !== resets_only()) begin
            errors++;
            $display("FAIL mid_exec_reset: got %h expected %h", act, resets_only());
        end
        @(negedge clock_in);
        act = sample();
        checks++;
        if (act.dmem_wr !== 1'b0 || act !== resets_only()) begin
            errors++;
            $display("FAIL mid_exec_reset_hold: got %h expected %h", act, resets_only());
        end
        @(posedge clock_in); #1;
        data_ready_in = 1'b0;
        release_reset("mid_exec");
    endtask

    task automatic test_zero_wait();
        int cyc;
        run_instr(LDI, 0, 0, 1'b0, 1'b0, cyc);
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL ldi_latency: got %0d expected 3", cyc);
        end
        run_instr(ADDI, 0, 0, 1'b0, 1'b0, cyc);
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL addi_latency: got %0d expected 3", cyc);
        end
        run_instr(STO, 0, 0, 1'b0, 1'b0, cyc);
        run_instr(LD, 0, 0, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_wait_states();
        int cyc;
        run_instr(SUB, 2, 3, 1'b0, 1'b1, cyc);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL sub_wait_latency: got %0d expected 8", cyc);
        end
        run_instr(STO, 1, 4, 1'b1, 1'b0, cyc);
        run_instr(LD, 3, 2, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_branch_sweep();
        int cyc;
        for (int op = 8; op <= 14; op++) begin
            for (int zn = 0; zn < 4; zn++) begin
                run_instr(5'(op), $urandom_range(0, 2), 0, zn[1], zn[0], cyc);
            end
        end
    endtask

    task automatic test_undefined();
        int cyc;
        run_instr(5'b10101, 1, 0, 1'b1, 1'b1, cyc);
        run_instr(5'b01111, 0, 0, 1'b0, 1'b1, cyc);
        run_instr(5'b11111, 0, 0, 1'b1, 1'b0, cyc);
    endtask

    task automatic test_random();
        int cyc;
        for (int k = 0; k < 40; k++) begin
            run_instr(5'($urandom_range(1, 31)), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), 1'($urandom), cyc);
        end
    endtask

    task automatic test_halt();
        int   cyc;
        ctl_t act, exp;
        run_instr(HLT, 1, 2, 1'b0, 1'b0, cyc);
        exp = '0; exp.halted = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instr_ready_in = 1'($urandom);
            data_ready_in  = 1'($urandom);
            op_code        = 5'($urandom);
            @(negedge clock_in);
            act = sample();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL halt_hold cycle=%0d: got %h expected %h", i, act, exp);
            end
            @(posedge clock_in); #1;
        end
        reset_in = 1'b0;
        #1;
        act = sample();
        checks++;
        if (act !== resets_only()) begin
            errors++;
            $display("FAIL halt_reset: got %h expected %h", act, resets_only());
        end
        @(posedge clock_in); #1;
        release_reset("after_halt");
        run_instr(LDI, 0, 0, 1'b0, 1'b0, cyc);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch_sweep();
        test_undefined();
        test_random();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_sequencer.md
Name: multicycle_control_sequencer

Overview:
- Multi-cycle FSM that sequences the accumulator CPU datapath through the phases FETCH, DECODE and EXECUTE.
- Drives the same control-signal set as the combinational decoder (PC, IR, ACC, status, data memory, muxes, ALU op, register resets).
- Adds wait-state handshakes with instruction and data memory, a HALT state and power-on register clearing.
- Sits between the instruction register, the status register and the datapath; replaces single-cycle control when memories are slow.

Parameters:
DATA_WIDTH, 11, operand/immediate width carried in the instruction
INSTRUCTION_WIDTH, 15, instruction width
OPCODE_WIDTH, INSTRUCTION_WIDTH-DATA_WIDTH+1 (=5), opcode field width

Ports:
clock_in  input  1  system clock, rising edge
reset_in  input  1  asynchronous, active-low reset
op_code  input  OPCODE_WIDTH  opcode field from the IR output
status_Z_in  input  1  zero flag from the status register
status_N_in  input  1  negative flag from the status register
instr_ready_in  input  1  instruction memory data valid / request accepted
data_ready_in  input  1  data memory read data valid / write accepted
instr_req_out  output  1  instruction fetch request
data_req_out  output  1  data memory access request
branch_out  output  1  PC source: 1 = branch target, 0 = PC+1
sel_A_out  output  2  ACC input mux: 00 ALU, 01 IR immediate, 10 data memory
sel_B_out  output  1  ALU B operand: 0 data memory, 1 IR immediate
alu_op_out  output  1  0 add, 1 subtract
data_memory_wr_out  output  1  data memory write strobe
acc_wr_out, pc_wr_out, status_wr_out, ir_wr_out  output  1 each  register write enables
acc_reset_out, pc_reset_out, status_reset_out, ir_reset_out  output  1 each  synchronous register clears
halted_out  output  1  core stopped on HLT

Behaviour:
- States: INIT, FETCH, DECODE, EXEC, HALT. Binary-encoded state register, asynchronous clear on reset_in=0.
- Outputs are combinational from state, latched opcode (opcode_q), flags and ready inputs.
- Reset (reset_in=0, any time, including mid-instruction):
  - state forced to INIT; opcode_q=0.
  - All *_reset_out=1; all other outputs 0 (sel_A_out=00).
  - Pending memory requests are dropped; no write enable may glitch high.
- INIT: the first clock after reset release holds all *_reset_out=1 for exactly one cycle, then goes to FETCH.
- FETCH:
  - instr_req_out=1.
  - If instr_ready_in=1: ir_wr_out=1 and go to DECODE.
  - Otherwise stay in FETCH with all outputs unchanged (unbounded wait).
- DECODE: one cycle; opcode_q <= op_code; no enables asserted; go to EXEC.
- EXEC, by opcode_q (every exit to FETCH asserts pc_wr_out=1 in that same cycle):
  - 00000 HLT: no enables; go to HALT. The PC is not written.
  - 00001 STO: data_req_out=1. When data_ready_in=1: data_memory_wr_out=1 (one cycle only), pc_wr_out=1, go to FETCH.
  - 00010 LD: data_req_out=1. When data_ready_in=1: sel_A=10, acc_wr=1, status_wr=1, pc_wr=1, go to FETCH.
  - 00011 LDI: sel_A=01, acc_wr, status_wr, pc_wr; go to FETCH; no memory access.
  - 00100 ADD / 00110 SUB: data_req_out=1. When data_ready_in=1: sel_A=00, sel_B=0, alu_op=0/1, acc_wr, status_wr, pc_wr.
  - 00101 ADDI / 00111 SUBI: sel_A=00, sel_B=1, alu_op=0/1, acc_wr, status_wr, pc_wr; single cycle.
  - Branches, with pc_wr=1 and branch_out=condition:
    - 01000 BEQ: Z
    - 01001 BNE: !Z
    - 01010 BGT: !Z&!N
    - 01011 BGE: !N
    - 01100 BLT: N
    - 01101 BLE: N|Z
    - 01110 JMP: 1
  - Flags are sampled in the EXEC cycle.
  - 01111–11111: NOP; pc_wr=1, branch_out=0.
  - While an EXEC data access waits (data_ready_in=0): data_req_out held at 1, all write enables 0.
- HALT: halted_out=1; all enables 0; remain until reset_in=0.
- Latency with zero wait states:
  - Immediate/ALU-immediate/branch: 3 cycles (FETCH, DECODE, EXEC).
  - Memory ops: 3 + data wait cycles.
  - Every instruction: + instruction wait cycles.
- Simultaneous ready in the same cycle the request first asserts is valid (zero-wait memory).
- Ready inputs are ignored in states that are not requesting them.

Test Plan:
- Reset: reset_in=0 mid-EXEC of STO with data_ready_in=0 -> all *_reset_out=1, data_memory_wr_out=0 immediately. After release: one INIT cycle, then instr_req_out=1.
- Zero-wait LDI then ADDI (readies tied 1) -> ir_wr at cycles 1 and 4 after INIT; EXEC cycles show sel_A=01/acc_wr, then sel_A=00, sel_B=1, alu_op=0; each takes 3 cycles.
- Wait states: SUB with instr_ready_in low 2 cycles and data_ready_in low 3 cycles -> instruction completes in 8 cycles; acc_wr, status_wr, pc_wr pulse exactly once with alu_op=1.
- Branch sweep: each of BEQ..BLE under all four (Z,N) combinations, plus JMP -> branch_out matches the condition table; pc_wr=1 every time.
- HLT -> halted_out=1 and no pc_wr for 20 cycles; reset_in pulse low -> halted_out=0 and fetch restarts.
- Undefined opcode 10101 -> pc_wr=1, branch_out=0, no acc/status/memory writes.
